// File: rtl/morse_round_sequencer.sv
// Game-round sequencer feeding the number-to-Morse display decoder.
// Walks a fixed 16-digit challenge ROM, scores submitted answers and runs
// the round countdown that raises timeout.
module morse_round_sequencer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ROUND_SECONDS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] answer,
  input  logic       submit,
  input  logic       logout_from_gamecontrol,
  output logic [3:0] number,
  output logic       timeout,
  output logic       round_active,
  output logic       correct,
  output logic       wrong,
  output logic [7:0] score,
  output logic [5:0] sec_left
);

  localparam int             PW       = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  PRE_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0]     SEC_INIT = 6'(ROUND_SECONDS);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW, EXPIRED} state_t;

  state_t        state, state_nxt;
  logic [3:0]    addr, addr_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [3:0]    number_nxt;
  logic          timeout_nxt, correct_nxt, wrong_nxt;
  logic [7:0]    score_nxt;
  logic [5:0]    sec_nxt;
  logic          running, tick, expire;

  // Challenge digits; the number register is the registered read port.
  function automatic logic [3:0] rom_rd(input logic [3:0] a);
    case (a)
      4'd0:  rom_rd = 4'd3;
      4'd1:  rom_rd = 4'd7;
      4'd2:  rom_rd = 4'd1;
      4'd3:  rom_rd = 4'd9;
      4'd4:  rom_rd = 4'd0;
      4'd5:  rom_rd = 4'd5;
      4'd6:  rom_rd = 4'd8;
      4'd7:  rom_rd = 4'd2;
      4'd8:  rom_rd = 4'd6;
      4'd9:  rom_rd = 4'd4;
      4'd10: rom_rd = 4'd9;
      4'd11: rom_rd = 4'd1;
      4'd12: rom_rd = 4'd7;
      4'd13: rom_rd = 4'd3;
      4'd14: rom_rd = 4'd5;
      default: rom_rd = 4'd0;
    endcase
  endfunction

  assign round_active = (state == LOAD) || (state == SHOW);

  // Next-state and next-output logic; priority logout > expiry > submit > start.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    pre_nxt     = pre;
    number_nxt  = number;
    timeout_nxt = timeout;
    score_nxt   = score;
    sec_nxt     = sec_left;
    correct_nxt = 1'b0;
    wrong_nxt   = 1'b0;
    tick        = 1'b0;
    running     = (state == LOAD) || (state == SHOW);
    // Prescaler only advances while a round is live; it holds otherwise.
    if (running) begin
      if (pre == PRE_MAX) begin
        pre_nxt = '0;
        tick    = 1'b1;
      end else begin
        pre_nxt = pre + 1'b1;
      end
    end
    expire = tick && (sec_left == 6'd1);

    if (logout_from_gamecontrol) begin
      state_nxt   = IDLE;
      addr_nxt    = '0;
      pre_nxt     = '0;
      number_nxt  = '0;
      timeout_nxt = 1'b0;
      score_nxt   = '0;
      sec_nxt     = '0;
    end else begin
      if (tick) sec_nxt = sec_left - 6'd1;
      case (state)
        IDLE, EXPIRED: begin
          if (start) begin
            state_nxt   = LOAD;
            addr_nxt    = '0;
            score_nxt   = '0;
            sec_nxt     = SEC_INIT;
            pre_nxt     = '0;
            timeout_nxt = 1'b0;
          end
        end
        LOAD: begin
          if (expire) begin
            state_nxt   = EXPIRED;
            timeout_nxt = 1'b1;
          end else begin
            number_nxt = rom_rd(addr);
            state_nxt  = SHOW;
          end
        end
        SHOW: begin
          if (expire) begin
            // A submit landing on the expiry edge is dropped.
            state_nxt   = EXPIRED;
            timeout_nxt = 1'b1;
          end else if (submit) begin
            if (answer == number) begin
              correct_nxt = 1'b1;
              if (score != 8'hFF) score_nxt = score + 8'd1;
              addr_nxt  = addr + 4'd1;
              state_nxt = LOAD;
            end else begin
              wrong_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      pre      <= '0;
      number   <= '0;
      timeout  <= 1'b0;
      correct  <= 1'b0;
      wrong    <= 1'b0;
      score    <= '0;
      sec_left <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      pre      <= pre_nxt;
      number   <= number_nxt;
      timeout  <= timeout_nxt;
      correct  <= correct_nxt;
      wrong    <= wrong_nxt;
      score    <= score_nxt;
      sec_left <= sec_nxt;
    end
  end

endmodule

// File: tb/tb_morse_round_sequencer.sv
// Bench for morse_round_sequencer: directed scenarios plus a randomized run
// against a round-level reference model (elapsed-cycle arithmetic).
module tb_morse_round_sequencer;

  localparam int TA = 4;
  localparam int RA = 3;

  logic       clk, rst;
  logic       start, submit, logout;
  logic [3:0] answer;
  logic [3:0] number;
  logic       timeout, round_active, correct, wrong;
  logic [7:0] score;
  logic [5:0] sec_left;

  logic       start_b, submit_b, logout_b;
  logic [3:0] answer_b;
  logic [3:0] number_b;
  logic       timeout_b, round_active_b, correct_b, wrong_b;
  logic [7:0] score_b;
  logic [5:0] sec_left_b;

  int checks = 0;
  int errors = 0;

  logic [3:0] rom [16] = '{4'd3, 4'd7, 4'd1, 4'd9, 4'd0, 4'd5, 4'd8, 4'd2,
                           4'd6, 4'd4, 4'd9, 4'd1, 4'd7, 4'd3, 4'd5, 4'd0};

  // Reference model: phase 0 idle, 1 load, 2 show, 3 expired.
  int         m_phase, m_elapsed, m_addr, m_score;
  logic [3:0] m_number;
  logic       m_timeout, m_cor, m_wr;

  morse_round_sequencer #(.TICKS_PER_SEC(TA), .ROUND_SECONDS(RA)) u_a (
    .clk(clk), .rst(rst), .start(start), .answer(answer), .submit(submit),
    .logout_from_gamecontrol(logout), .number(number), .timeout(timeout),
    .round_active(round_active), .correct(correct), .wrong(wrong),
    .score(score), .sec_left(sec_left));

  morse_round_sequencer #(.TICKS_PER_SEC(1000), .ROUND_SECONDS(63)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .answer(answer_b), .submit(submit_b),
    .logout_from_gamecontrol(logout_b), .number(number_b), .timeout(timeout_b),
    .round_active(round_active_b), .correct(correct_b), .wrong(wrong_b),
    .score(score_b), .sec_left(sec_left_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_addr = 0; m_score = 0;
    m_number = '0; m_timeout = 1'b0; m_cor = 1'b0; m_wr = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic sub, input logic [3:0] ans, input logic lo);
    m_cor = 1'b0; m_wr = 1'b0;
    if (lo) begin
      model_reset();
    end else if (m_phase == 0 || m_phase == 3) begin
      if (st) begin
        m_phase = 1; m_addr = 0; m_score = 0; m_elapsed = 0; m_timeout = 1'b0;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == RA * TA) begin
        m_phase = 3; m_timeout = 1'b1;
      end else if (m_phase == 1) begin
        m_number = rom[m_addr]; m_phase = 2;
      end else if (sub) begin
        if (ans == m_number) begin
          m_cor = 1'b1;
          if (m_score < 255) m_score++;
          m_addr = (m_addr + 1) % 16;
          m_phase = 1;
        end else begin
          m_wr = 1'b1;
        end
      end
    end
  endtask

  function automatic int m_sec();
    return (m_phase == 1 || m_phase == 2) ? RA - m_elapsed / TA : 0;
  endfunction

  // One clock of DUT A (DUT B sees whatever its own inputs hold).
  task automatic cyc(input logic st, input logic sub, input logic [3:0] ans, input logic lo);
    start = st; submit = sub; answer = ans; logout = lo;
    @(posedge clk);
    model_edge(st, sub, ans, lo);
    #1;
    start = 1'b0; submit = 1'b0; logout = 1'b0;
  endtask

  // One clock of DUT B; DUT A idles with zero inputs.
  task automatic cyc_b(input logic st, input logic sub, input logic [3:0] ans);
    start_b = st; submit_b = sub; answer_b = ans;
    cyc(1'b0, 1'b0, 4'd0, 1'b0);
    start_b = 1'b0; submit_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 0; submit = 0; answer = 0; logout = 0;
    start_b = 0; submit_b = 0; answer_b = 0; logout_b = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc(0, 0, 4'd0, 0);
    checks++; if (number !== 4'd0) begin errors++; $display("FAIL reset_number got %0d want 0", number); end
    checks++; if ({timeout, round_active, correct, wrong} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {timeout, round_active, correct, wrong}); end
    checks++; if (score !== 8'd0 || sec_left !== 6'd0) begin errors++; $display("FAIL reset_counts got score=%0d sec=%0d want 0 0", score, sec_left); end
    // Reset must act without waiting for a clock edge.
    cyc(1, 0, 4'd0, 0);
    #2 rst = 1'b0;
    #1;
    checks++; if (round_active !== 1'b0 || sec_left !== 6'd0) begin errors++; $display("FAIL async_reset got act=%b sec=%0d want 0 0", round_active, sec_left); end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_start();
    cyc(1, 0, 4'd0, 0);
    checks++; if (round_active !== 1'b1) begin errors++; $display("FAIL start_active got %b want 1", round_active); end
    checks++; if (sec_left !== 6'd3) begin errors++; $display("FAIL start_sec got %0d want 3", sec_left); end
    cyc(0, 0, 4'd0, 0);
    checks++; if (number !== 4'd3) begin errors++; $display("FAIL start_number got %0d want 3", number); end
  endtask

  task automatic test_correct();
    int cor_cnt;
    logic [3:0] digs [3] = '{4'd3, 4'd7, 4'd1};
    cor_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, digs[i], 0);
      if (correct === 1'b1) cor_cnt++;
      checks++; if (score !== 8'(i + 1)) begin errors++; $display("FAIL correct_score%0d got %0d want %0d", i, score, i + 1); end
      cyc(0, 0, 4'd0, 0);
      checks++; if (correct !== 1'b0) begin errors++; $display("FAIL correct_pulse_width%0d got %b want 0", i, correct); end
    end
    checks++; if (cor_cnt != 3) begin errors++; $display("FAIL correct_pulses got %0d want 3", cor_cnt); end
    checks++; if (number !== 4'd9) begin errors++; $display("FAIL correct_next_number got %0d want 9", number); end
  endtask

  task automatic test_wrong();
    cyc(0, 0, 4'd0, 1);
    cyc(1, 0, 4'd0, 0);
    cyc(0, 0, 4'd0, 0);
    cyc(0, 1, 4'd5, 0);
    checks++; if (wrong !== 1'b1 || correct !== 1'b0) begin errors++; $display("FAIL wrong_pulse got w=%b c=%b want 1 0", wrong, correct); end
    checks++; if (number !== 4'd3 || score !== 8'd0) begin errors++; $display("FAIL wrong_hold got num=%0d score=%0d want 3 0", number, score); end
    cyc(0, 0, 4'd0, 0);
    checks++; if (wrong !== 1'b0 || round_active !== 1'b1) begin errors++; $display("FAIL wrong_after got w=%b act=%b want 0 1", wrong, round_active); end
  endtask

  task automatic test_expiry();
    cyc(0, 0, 4'd0, 1);
    cyc(1, 0, 4'd0, 0);
    for (int k = 1; k <= RA * TA; k++) begin
      cyc(0, 0, 4'd0, 0);
      if (k < RA * TA) begin
        checks++; if (sec_left !== 6'(RA - k / TA) || timeout !== 1'b0) begin errors++; $display("FAIL expiry_count k=%0d got sec=%0d to=%b want %0d 0", k, sec_left, timeout, RA - k / TA); end
      end else begin
        checks++; if (timeout !== 1'b1 || sec_left !== 6'd0 || round_active !== 1'b0) begin errors++; $display("FAIL expiry_edge got to=%b sec=%0d act=%b want 1 0 0", timeout, sec_left, round_active); end
      end
    end
    cyc(0, 1, 4'd3, 0);
    checks++; if (correct !== 1'b0 || wrong !== 1'b0 || score !== 8'd0 || number !== 4'd3) begin errors++; $display("FAIL expired_submit got c=%b w=%b score=%0d num=%0d want 0 0 0 3", correct, wrong, score, number); end
    cyc(1, 0, 4'd0, 0);
    checks++; if (timeout !== 1'b0 || sec_left !== 6'd3) begin errors++; $display("FAIL restart got to=%b sec=%0d want 0 3", timeout, sec_left); end
    cyc(0, 0, 4'd0, 0);
    checks++; if (number !== 4'd3) begin errors++; $display("FAIL restart_number got %0d want 3", number); end
  endtask

  task automatic test_collision_logout();
    cyc(0, 0, 4'd0, 1);
    cyc(1, 0, 4'd0, 0);
    for (int k = 1; k < RA * TA; k++) cyc(0, 0, 4'd0, 0);
    cyc(0, 1, 4'd3, 0);
    checks++; if (timeout !== 1'b1 || correct !== 1'b0 || score !== 8'd0) begin errors++; $display("FAIL collision got to=%b c=%b score=%0d want 1 0 0", timeout, correct, score); end
    cyc(0, 0, 4'd0, 1);
    cyc(1, 0, 4'd0, 0);
    cyc(0, 0, 4'd0, 0);
    cyc(0, 1, 4'd3, 0);
    cyc(0, 0, 4'd0, 0);
    cyc(1, 0, 4'd0, 1);
    checks++; if ({number, timeout, round_active, correct, wrong, score, sec_left} !== '0) begin errors++; $display("FAIL logout_clear got num=%0d to=%b act=%b sc=%0d sec=%0d want all 0", number, timeout, round_active, score, sec_left); end
    cyc(1, 0, 4'd0, 1);
    cyc(0, 0, 4'd0, 0);
    checks++; if (round_active !== 1'b0 || sec_left !== 6'd0) begin errors++; $display("FAIL logout_start_ignored got act=%b sec=%0d want 0 0", round_active, sec_left); end
  endtask

  task automatic test_random();
    logic st, sub, lo;
    logic [3:0] ans;
    cyc(0, 0, 4'd0, 1);
    for (int i = 0; i < 500; i++) begin
      st  = ($urandom % 8) == 0;
      sub = ($urandom % 3) == 0;
      ans = ($urandom % 2) ? m_number : 4'($urandom % 16);
      lo  = ($urandom % 50) == 0;
      cyc(st, sub, ans, lo);
      checks++; if (number !== m_number) begin errors++; $display("FAIL rnd_number cyc=%0d got %0d want %0d", i, number, m_number); end
      checks++; if (timeout !== m_timeout) begin errors++; $display("FAIL rnd_timeout cyc=%0d got %b want %b", i, timeout, m_timeout); end
      checks++; if (round_active !== (m_phase == 1 || m_phase == 2)) begin errors++; $display("FAIL rnd_active cyc=%0d got %b want %0d", i, round_active, m_phase); end
      checks++; if (correct !== m_cor || wrong !== m_wr) begin errors++; $display("FAIL rnd_pulses cyc=%0d got c=%b w=%b want %b %b", i, correct, wrong, m_cor, m_wr); end
      checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL rnd_score cyc=%0d got %0d want %0d", i, score, m_score); end
      checks++; if (sec_left !== 6'(m_sec())) begin errors++; $display("FAIL rnd_sec cyc=%0d got %0d want %0d", i, sec_left, m_sec()); end
    end
  endtask

  task automatic test_wrap_saturate();
    int miss;
    miss = 0;
    cyc_b(1, 0, 4'd0);
    cyc_b(0, 0, 4'd0);
    checks++; if (number_b !== 4'd3) begin errors++; $display("FAIL b_first got %0d want 3", number_b); end
    for (int i = 0; i < 260; i++) begin
      cyc_b(0, 1, rom[i % 16]);
      if (correct_b !== 1'b1) miss++;
      cyc_b(0, 0, 4'd0);
      if (i == 15) begin
        checks++; if (number_b !== 4'd3 || score_b !== 8'd16) begin errors++; $display("FAIL b_wrap got num=%0d score=%0d want 3 16", number_b, score_b); end
      end
    end
    checks++; if (miss != 0) begin errors++; $display("FAIL b_correct_pulses got %0d missing want 0", miss); end
    checks++; if (score_b !== 8'd255) begin errors++; $display("FAIL b_saturate got %0d want 255", score_b); end
    checks++; if (round_active_b !== 1'b1 || timeout_b !== 1'b0 || wrong_b !== 1'b0 || sec_left_b !== 6'd63) begin errors++; $display("FAIL b_state got act=%b to=%b w=%b sec=%0d want 1 0 0 63", round_active_b, timeout_b, wrong_b, sec_left_b); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_correct();
    test_wrong();
    test_expiry();
    test_collision_logout();
    test_random();
    test_wrap_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_round_sequencer.md
# morse_round_sequencer

Game-round sequencer that sits directly upstream of the number-to-Morse display decoder. It reads the challenge digits from an internal 16-entry ROM and presents the current digit on `number`. It checks the player's submitted answer against that digit and runs the round countdown that raises `timeout`. Its `number` and `timeout` outputs connect straight to the decoder's inputs of the same names.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per countdown second; legal range ≥2.
- `ROUND_SECONDS`, default 30: round length in seconds; legal range 1..63.

Ports:
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that begins a round; already synchronised.
- `answer`  in  4: player's digit from the switches.
- `submit`  in  1: one-cycle pulse that samples `answer`; already debounced.
- `logout_from_gamecontrol`  in  1: level input; aborts the round while high.
- `number`  out  4: current challenge digit, registered.
- `timeout`  out  1: high from round expiry until the next start or logout.
- `round_active`  out  1: high in LOAD and SHOW.
- `correct`  out  1: one-cycle pulse on a matching submit.
- `wrong`  out  1: one-cycle pulse on a mismatching submit.
- `score`  out  8: count of correct answers this round; saturates at 255.
- `sec_left`  out  6: seconds remaining in the round.

## Operation
ROM contents, address 0..15: 3, 7, 1, 9, 0, 5, 8, 2, 6, 4, 9, 1, 7, 3, 5, 0.
- ROM read is registered.
- The 4-bit address wraps from 15 to 0.

States: IDLE, LOAD, SHOW, EXPIRED.
- IDLE: `start` → LOAD. At the same edge: `addr`=0, `score`=0, `sec_left`=ROUND_SECONDS, prescaler=0.
- EXPIRED: `start` → LOAD with the same initialisation. `timeout` clears at that edge.
- LOAD: unconditional → SHOW. `number` takes ROM[addr] at this edge.
- SHOW, `submit` with `answer`==`number`:
  - `correct` pulses.
  - `score` increments, holding at 255.
  - `addr` increments, wrapping.
  - Next state LOAD.
- SHOW, `submit` with a mismatch: `wrong` pulses and the block stays in SHOW. Score and addr are unchanged.
- `start` in LOAD or SHOW is ignored.
- `submit` outside SHOW is ignored.

Countdown:
- The prescaler counts 0..TICKS_PER_SEC-1 only in LOAD and SHOW. It holds its value elsewhere.
- On wrap the prescaler issues a tick and `sec_left` decrements.
- A tick while `sec_left`==1 sets `sec_left`=0 and `timeout`=1, and moves the block to EXPIRED from either LOAD or SHOW.
- In EXPIRED, `number` holds its last value and `score` holds.

Priority, highest first: reset, `logout_from_gamecontrol`, expiry tick, `submit`, `start`.
- Logout high forces IDLE from any state.
- Logout clears `number`, `timeout`, `score`, `addr`, `sec_left`, prescaler and both pulses.
- All outputs stay cleared while logout is high. `start` is ignored until logout drops.
- An expiry tick in the same cycle as `submit`: expiry wins. The submit is discarded and neither pulse fires.

## Timing
- Reset value of every output is 0: number=0, timeout=0, round_active=0, correct=0, wrong=0, score=0, sec_left=0. State is IDLE.
- Reset assertion is immediate (asynchronous). Release is synchronous to `clk`.
- `start` sampled at edge N:
  - LOAD at N.
  - `number` valid after edge N+1.
  - `round_active` high after edge N.
- Correct `submit` sampled at edge M:
  - `correct` and the `score` update are visible after edge M, for one cycle.
  - The new `number` is visible after edge M+1.
  - Each correct answer costs one LOAD cycle. The countdown keeps running during LOAD.
- `timeout` rises exactly ROUND_SECONDS×TICKS_PER_SEC cycles after the `start` edge.
- `logout_from_gamecontrol` takes effect at the first edge where it is sampled high.

## Test plan
Use TICKS_PER_SEC=4 and ROUND_SECONDS=3 unless a scenario says otherwise.
- Reset then start:
  - Hold `rst`=0, then release.
  - Required: all outputs 0.
  - Pulse `start` → `number`=3 two edges later, `sec_left`=3, `round_active`=1.
- Correct answers:
  - Submit 3, 7, 1 on successive SHOW phases.
  - Required: three `correct` pulses, `score`=3, then `number`=9.
- Wrong answer:
  - In SHOW with `number`=3, submit 5.
  - Required: one `wrong` pulse; `number`=3 and `score`=0 unchanged.
- Expiry:
  - Take no action after start.
  - Required: `sec_left` steps 3→2→1→0 every 4 cycles; `timeout`=1 exactly 12 cycles after the start edge.
  - Required: a submit during EXPIRED has no effect; a new `start` clears `timeout` and shows 3.
- Collision and logout:
  - Drive `submit` with the correct digit on the expiry cycle → `timeout`=1, no `correct` pulse, score unchanged.
  - Assert logout mid-SHOW → all outputs 0 on the next edge; `start` is ignored while logout is high.
- Wrap and saturation:
  - Set ROUND_SECONDS=63 and TICKS_PER_SEC=1000.
  - Answer 16 digits correctly → the 17th `number` shown is 3, i.e. `addr` wrapped to 0.
  - Force 260 correct answers → `score` holds at 255.
